// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel programmable clock divider with toggle and pulse modes
module clk_div_multi #(
  parameter int CHANNELS    = 2,
  parameter int WIDTH       = 26,
  parameter int DEFAULT_DIV = 49999999
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] div_value,
  input  logic [CHANNELS-1:0]       mode,
  output logic [CHANNELS-1:0]       clk_d,
  output logic [CHANNELS-1:0]       tick
);

  localparam logic [WIDTH-1:0] DEFAULT_Q = WIDTH'(DEFAULT_DIV);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] count;
    logic             clk_d_q;
    logic             tick_q;
    logic             term;

    // Terminal count: enabled, counter at the divide value, and not being reloaded
    always_comb begin
      term = enable[i] & (count == div_q) & ~load[i];
    end

    // Per-channel state: load wins over counting, disabled channels freeze except tick
    always_ff @(posedge clk) begin
      if (reset) begin
        div_q   <= DEFAULT_Q;
        count   <= '0;
        clk_d_q <= 1'b0;
        tick_q  <= 1'b0;
      end else if (load[i]) begin
        div_q  <= div_value[i*WIDTH +: WIDTH];
        count  <= '0;
        tick_q <= 1'b0;
      end else if (enable[i]) begin
        count  <= term ? '0 : count + WIDTH'(1);
        tick_q <= term;
        if (mode[i]) begin
          clk_d_q <= term;
        end else if (term) begin
          clk_d_q <= ~clk_d_q;
        end
      end else begin
        tick_q <= 1'b0;
      end
    end

    assign clk_d[i] = clk_d_q;
    assign tick[i]  = tick_q;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - scoreboard bench for clk_div_multi
module tb_clk_div_multi;

  typedef struct {
    int   at;
    logic cd;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [1:0]  enable;
  logic [1:0]  load;
  logic [15:0] div_value;
  logic [1:0]  mode;
  logic [1:0]  clk_d;
  logic [1:0]  tick;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   mon_on = 0;
  bit   pulse_chk [2];
  exp_t exp_q [2][$];

  clk_div_multi #(
    .CHANNELS   (2),
    .WIDTH      (8),
    .DEFAULT_DIV(10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .load     (load),
    .div_value(div_value),
    .mode     (mode),
    .clk_d    (clk_d),
    .tick     (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: after posedge k, cyc == k
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic push_ticks(input int ch, input int first, input int period, input int n,
                            input logic first_cd, input bit toggle);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.at = first + k * period;
      e.cd = toggle ? (first_cd ^ k[0]) : first_cd;
      exp_q[ch].push_back(e);
    end
  endtask

  task automatic push_one(input int ch, input int at, input logic cd);
    exp_t e;
    e.at = at;
    e.cd = cd;
    exp_q[ch].push_back(e);
  endtask

  // Monitor: every tick must match the head of that channel's expected queue
  always @(negedge clk) begin
    if (mon_on) begin
      for (int c = 0; c < 2; c++) begin
        while (exp_q[c].size() > 0 && exp_q[c][0].at < cyc) begin
          checks++;
          errors++;
          $display("FAIL missed_tick ch%0d: no tick at edge %0d (now %0d)", c, exp_q[c][0].at, cyc);
          void'(exp_q[c].pop_front());
        end
        if (tick[c] === 1'b1) begin
          checks++;
          if (exp_q[c].size() == 0 || exp_q[c][0].at != cyc) begin
            errors++;
            $display("FAIL unexpected_tick ch%0d: tick at edge %0d, next expected %0d", c, cyc,
                     (exp_q[c].size() == 0) ? -1 : exp_q[c][0].at);
          end else begin
            exp_t e;
            e = exp_q[c].pop_front();
            if (clk_d[c] !== e.cd) begin
              errors++;
              $display("FAIL tick_clk_d ch%0d at edge %0d: got %b, expected %b", c, cyc, clk_d[c], e.cd);
            end
          end
        end else if (tick[c] !== 1'b0) begin
          checks++;
          errors++;
          $display("FAIL tick_unknown ch%0d at edge %0d: got %b", c, cyc, tick[c]);
        end
        if (pulse_chk[c]) begin
          checks++;
          if (clk_d[c] !== tick[c]) begin
            errors++;
            $display("FAIL pulse_eq_tick ch%0d at edge %0d: clk_d %b, tick %b", c, cyc, clk_d[c], tick[c]);
          end
        end
      end
    end
  end

  initial begin
    int l;
    int r;
    pulse_chk[0] = 0;
    pulse_chk[1] = 0;
    reset = 1'b1;
    enable = 2'b00;
    load = 2'b00;
    div_value = '0;
    mode = 2'b00;
    step();
    step();
    chk("reset_clk_d", clk_d, 2'b00);
    chk("reset_tick", tick, 2'b00);
    mon_on = 1;
    reset = 1'b0;

    // ch0 div 3 toggle, ch1 div 4 pulse, both running together
    load = 2'b11;
    div_value = {8'd4, 8'd3};
    mode = 2'b10;
    step();
    l = cyc;
    load = 2'b00;
    enable = 2'b11;
    pulse_chk[1] = 1;
    push_ticks(0, l + 4, 4, 5, 1'b1, 1'b1);
    push_ticks(1, l + 5, 5, 4, 1'b1, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      step();
      chk("square_level_ch0", {1'b0, clk_d[0]}, {1'b0, ((k / 4) % 2) == 1});
    end
    pulse_chk[1] = 0;
    enable = 2'b00;

    // ch0 div 0: clk/2 in toggle mode, then constant high in pulse mode
    load = 2'b01;
    div_value[7:0] = 8'd0;
    mode[0] = 1'b0;
    step();
    l = cyc;
    chk("load_holds_clk_d", {1'b0, clk_d[0]}, 2'b01);
    load = 2'b00;
    enable = 2'b01;
    push_ticks(0, l + 1, 1, 6, 1'b0, 1'b1);
    repeat (6) step();
    mode[0] = 1'b1;
    pulse_chk[0] = 1;
    push_ticks(0, l + 7, 1, 6, 1'b1, 1'b0);
    repeat (6) step();
    pulse_chk[0] = 0;
    enable = 2'b00;
    step();
    chk("disabled_tick_low", tick, 2'b00);

    // ch0 div 5: pause at count 2 for 7 cycles
    mode[0] = 1'b0;
    load = 2'b01;
    div_value[7:0] = 8'd5;
    step();
    l = cyc;
    load = 2'b00;
    enable = 2'b01;
    push_one(0, l + 13, 1'b0);
    push_one(0, l + 19, 1'b1);
    repeat (2) step();
    enable = 2'b00;
    repeat (7) begin
      step();
      chk("pause_hold_clk_d", {1'b0, clk_d[0]}, 2'b01);
    end
    enable = 2'b01;
    repeat (10) step();
    enable = 2'b00;
    step();

    // Load coincident with terminal count: load wins
    l = cyc;
    enable = 2'b01;
    repeat (5) step();
    load = 2'b01;
    div_value[7:0] = 8'd2;
    push_one(0, l + 9, 1'b0);
    push_one(0, l + 12, 1'b1);
    step();
    chk("collide_tick", tick, 2'b00);
    chk("collide_clk_d", {1'b0, clk_d[0]}, 2'b01);
    load = 2'b00;
    repeat (6) step();
    enable = 2'b00;
    step();

    // Reset mid-period overrides a coincident load
    load = 2'b01;
    div_value[7:0] = 8'd7;
    step();
    load = 2'b00;
    enable = 2'b01;
    repeat (5) step();
    chk("pre_reset_clk_d", {1'b0, clk_d[0]}, 2'b01);
    reset = 1'b1;
    load = 2'b01;
    div_value[7:0] = 8'd3;
    step();
    r = cyc;
    chk("mid_reset_clk_d", clk_d, 2'b00);
    chk("mid_reset_tick", tick, 2'b00);
    reset = 1'b0;
    load = 2'b00;
    push_one(0, r + 11, 1'b1);
    push_one(0, r + 22, 1'b0);
    repeat (22) step();
    enable = 2'b00;
    step();
    step();

    for (int c = 0; c < 2; c++) begin
      checks++;
      if (exp_q[c].size() != 0) begin
        errors++;
        $display("FAIL leftover_expect ch%0d: %0d pending, expected 0", c, exp_q[c].size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
